// File: rtl/am2927_busctl.sv
// am2927_busctl: bus-cycle sequencer driving s/endr_/be_/rle_/oe_ of ganged am2927 transceivers
//
// Ports:
//   cp      clock, rising edge          clr     asynchronous active-high reset
//   wr_req  start write cycle (level)   rd_req  start read cycle (level)
//   bus_rdy bus acknowledge
//   s, endr_, be_, rle_, oe_            am2927 controls (active-low except s)
//   busy    not IDLE                    done    completion pulse
//   err     timeout pulse
//
// Optional feature: define AM2927_BUSCTL_TIMEOUT_EN to abort WDRIVE/RSAMP into TOUT after
// WAIT_MAX wait cycles without bus_rdy. Without it the wait counter is not built and err stays 0.
module am2927_busctl #(
    parameter int CNTW     = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic cp,
    input  logic clr,
    input  logic wr_req,
    input  logic rd_req,
    input  logic bus_rdy,
    output logic s,
    output logic endr_,
    output logic be_,
    output logic rle_,
    output logic oe_,
    output logic busy,
    output logic done,
    output logic err
);
    typedef enum logic [2:0] {IDLE, WLOAD, WDRIVE, WDONE, RSAMP, RHOLD, TOUT} state_t;

    state_t state, nxt;
    logic   yhold, yhold_nxt;
    logic   tmo;

    if (WAIT_MAX < 1 || WAIT_MAX >= 2 ** CNTW) begin : g_bad_param
        $error("am2927_busctl: WAIT_MAX out of range for CNTW");
    end

`ifdef AM2927_BUSCTL_TIMEOUT_EN
    logic [CNTW-1:0] cnt;

    assign tmo = (cnt == CNTW'(WAIT_MAX)) && !bus_rdy;

    // Cleared on any state change, so it reads 0 in the first cycle of WDRIVE/RSAMP.
    always_ff @(posedge cp or posedge clr) begin
        if (clr)
            cnt <= '0;
        else
            cnt <= (nxt != state) ? '0 : (cnt == '1) ? cnt : cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        nxt       = state;
        yhold_nxt = yhold;
        case (state)
            IDLE: begin
                if (wr_req || rd_req) yhold_nxt = 1'b0;
                nxt = wr_req ? WLOAD : rd_req ? RSAMP : IDLE;
            end
            WLOAD:   nxt = WDRIVE;
            WDRIVE:  nxt = bus_rdy ? WDONE : tmo ? TOUT : WDRIVE;
            WDONE:   nxt = IDLE;
            RSAMP:   nxt = bus_rdy ? RHOLD : tmo ? TOUT : RSAMP;
            RHOLD: begin
                nxt       = IDLE;
                yhold_nxt = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge cp or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            yhold <= 1'b0;
            s     <= 1'b1;
            endr_ <= 1'b1;
            be_   <= 1'b1;
            rle_  <= 1'b1;
            oe_   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            yhold <= yhold_nxt;
            s     <= nxt != WLOAD;
            endr_ <= nxt != WLOAD;
            be_   <= nxt != WDRIVE;
            rle_  <= nxt != RSAMP;
            oe_   <= (nxt == IDLE) ? !yhold_nxt : !(nxt == RSAMP || nxt == RHOLD);
            busy  <= nxt != IDLE;
            done  <= nxt == WDONE || nxt == RHOLD;
            err   <= nxt == TOUT;
        end
    end
endmodule
